// File: rtl/aes_inv_core_if.sv
// aes_inv_core_if: request, stall, status and data signals of the AES-128 decryption core
interface aes_inv_core_if;
    logic         start;
    logic [127:0] key;
    logic [127:0] ciphertext;
    logic         step_en;
    logic         busy;
    logic         done;
    logic [127:0] plaintext;
    logic [127:0] state;
    modport master (output start, key, ciphertext, step_en, input busy, done, plaintext, state);
    modport slave (input start, key, ciphertext, step_en, output busy, done, plaintext, state);
endinterface

// File: rtl/aes_inv_core.sv
// aes_inv_core: iterative AES-128 inverse cipher, one step per enabled cycle, on-the-fly inverse key schedule
module aes_inv_core (
    input logic           clk,
    input logic           rst,
    aes_inv_core_if.slave bus
);
    typedef enum logic [1:0] {IDLE, KEYEXP, DEC} fsm_t;
    fsm_t         fsm, fsm_nx;
    logic [127:0] st, rk, pt, nrk, isb, ark, imc;
    logic [4:0]   cnt;
    logic         pulse, step, last;
    logic [31:0]  kw, sw, f0, f1, f2, f3;
    logic [7:0]   rc;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // multiplicative inverse as a^254, which also maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, sq;
        r = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = ginv(a);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [4:0] n);
        case (n)
            5'd1:    return 8'h01;
            5'd2:    return 8'h02;
            5'd3:    return 8'h04;
            5'd4:    return 8'h08;
            5'd5:    return 8'h10;
            5'd6:    return 8'h20;
            5'd7:    return 8'h40;
            5'd8:    return 8'h80;
            5'd9:    return 8'h1b;
            5'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // row r rotates right by r columns; byte (row r, col c) sits at index 4c+r
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return o;
    endfunction

    // key path (4 forward S-boxes, shared by forward and inverse expansion) and data path evaluated together
    always_comb begin
        step = bus.step_en && fsm != IDLE;
        last = fsm == DEC && cnt == 5'd19;
        rc = rcon(fsm == KEYEXP ? cnt + 5'd1 : 5'd20 - cnt);
        kw = fsm == KEYEXP ? rk[31:0] : rk[31:0] ^ rk[63:32];
        sw = {sbox(kw[23:16]), sbox(kw[15:8]), sbox(kw[7:0]), sbox(kw[31:24])} ^ {rc, 24'h0};
        f0 = rk[127:96] ^ sw;
        f1 = rk[95:64] ^ f0;
        f2 = rk[63:32] ^ f1;
        f3 = rk[31:0] ^ f2;
        nrk = fsm == KEYEXP ? {f0, f1, f2, f3}
                            : {f0, rk[127:96] ^ rk[95:64], rk[95:64] ^ rk[63:32], rk[63:32] ^ rk[31:0]};
        isb = inv_sub_bytes(inv_shift_rows(st));
        ark = isb ^ nrk;
        imc = inv_mix(ark);
    end

    // next phase: load on start, leave key expansion after step 10, finish after step 20
    always_comb begin
        fsm_nx = fsm;
        if (fsm == IDLE && bus.start) fsm_nx = KEYEXP;
        else if (step && fsm == KEYEXP && cnt == 5'd9) fsm_nx = DEC;
        else if (step && last) fsm_nx = IDLE;
    end

    // phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm <= IDLE;
        else fsm <= fsm_nx;
    end

    // datapath, round key and step counter; everything holds on stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= '0;
            rk    <= '0;
            pt    <= '0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= step && last;
            if (fsm == IDLE && bus.start) begin
                st  <= bus.ciphertext;
                rk  <= bus.key;
                cnt <= '0;
            end else if (step) begin
                rk  <= nrk;
                cnt <= cnt + 5'd1;
                st  <= fsm == KEYEXP ? (cnt == 5'd9 ? st ^ nrk : st) : (last ? ark : imc);
                if (last) pt <= ark;
            end
        end
    end

    assign bus.busy      = fsm != IDLE;
    assign bus.done      = pulse;
    assign bus.plaintext = pt;
    assign bus.state     = st;
endmodule

// File: tb/tb_aes_inv_core.sv
// tb_aes_inv_core: known-answer, random (model-encrypted), stall, ignored-start, reset and back-to-back runs
module tb_aes_inv_core;
    logic clk, rst;
    aes_inv_core_if bus();
    aes_inv_core dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        logic [127:0] mid;
    } vec_t;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  sb [256];
    logic [15:0] lfsr;
    vec_t        vt [6];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] key_round(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcv;
        rcv = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcv, 24'h0};
                rcv = xt(rcv);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o, rkv;
        rkv = key_round(k, 0);
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rkv[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) t[r] = s[4*c+r];
                    for (int r = 0; r < 4; r++)
                        s[4*c+r] = xt(t[r]) ^ xt(t[(r+1)%4]) ^ t[(r+1)%4] ^ t[(r+2)%4] ^ t[(r+3)%4];
                end
            end
            rkv = key_round(k, rnd);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkv[127-8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one decryption from acceptance to the done cycle; returns while done is high
    task automatic decrypt(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt,
                           input logic [127:0] mid, input bit stall, input bit poke,
                           input bit hold_chk, input logic [127:0] hold);
        int           lat = 0;
        int           steps = 0;
        int           stalls = 0;
        bit           se, got = 0, frozen_ok = 1, held_ok = 1;
        logic [127:0] prev;
        bus.start = 1'b1;
        bus.key = k;
        bus.ciphertext = ct;
        bus.step_en = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.key = ~k;
        bus.ciphertext = ~ct;
        chk("busy_after_start", bus.busy, 1);
        for (int n = 1; n <= 100 && !got; n++) begin
            se = 1'b1;
            if (stall) begin
                se = lfsr[0] | lfsr[1];
                lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            end
            bus.step_en = se;
            bus.start = poke && (n == 3 || n == 15);
            if (bus.start) begin
                bus.key = 128'hffeeddccbbaa99887766554433221100;
                bus.ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            prev = bus.state;
            tick();
            if (!se) begin
                stalls++;
                if (bus.state !== prev) frozen_ok = 0;
            end else steps++;
            if (se && steps == 10) chk("state_after_rk10", bus.state, mid);
            if (hold_chk && !bus.done && bus.plaintext !== hold) held_ok = 0;
            got = bus.done;
            lat = n;
        end
        bus.start = 1'b0;
        bus.step_en = 1'b1;
        chk("done_seen", got, 1);
        chk("latency", lat, 20 + stalls);
        chk("plaintext", bus.plaintext, pt);
        chk("busy_at_done", bus.busy, 0);
        if (stall) chk("state_frozen_on_stall", frozen_ok, 1);
        if (hold_chk) chk("plaintext_hold", held_ok, 1);
    endtask

    // stimulus, reference tables and scoreboard
    initial begin
        logic [7:0]   p, q;
        logic [127:0] k, pt;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.key = '0;
        bus.ciphertext = '0;
        bus.step_en = 1'b1;
        lfsr = 16'hace1;
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ xt(p);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
        end
        sb[0] = 8'h63;
        vt[0] = '{C1_KEY, C1_CT, C1_PT, C1_CT ^ C1_RK};
        vt[1] = '{B_KEY, B_CT, B_PT, B_CT ^ key_round(B_KEY, 10)};
        for (int i = 2; i < 6; i++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            vt[i] = '{k, aes_enc(k, pt), pt, aes_enc(k, pt) ^ key_round(k, 10)};
        end
        repeat (3) tick();
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_plaintext", bus.plaintext, 0);
        chk("reset_state", bus.state, 0);
        rst = 1'b0;
        tick();
        chk("idle_no_start", bus.busy, 0);
        for (int i = 0; i < 6; i++) decrypt(vt[i].key, vt[i].ct, vt[i].pt, vt[i].mid, 0, 0, 0, '0);
        tick();
        decrypt(C1_KEY, C1_CT, C1_PT, C1_CT ^ C1_RK, 1, 0, 0, '0);
        tick();
        decrypt(C1_KEY, C1_CT, C1_PT, C1_CT ^ C1_RK, 0, 1, 0, '0);
        tick();
        chk("single_done", bus.done, 0);
        chk("idle_after_poke", bus.busy, 0);
        bus.start = 1'b1;
        bus.key = C1_KEY;
        bus.ciphertext = C1_CT;
        tick();
        bus.start = 1'b0;
        repeat (14) tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_plaintext", bus.plaintext, 0);
        chk("abort_state", bus.state, 0);
        tick();
        rst = 1'b0;
        tick();
        decrypt(B_KEY, B_CT, B_PT, vt[1].mid, 0, 0, 0, '0);
        tick();
        decrypt(B_KEY, B_CT, B_PT, vt[1].mid, 0, 0, 0, '0);
        chk("start_in_done_cycle", bus.done, 1);
        decrypt(C1_KEY, C1_CT, C1_PT, C1_CT ^ C1_RK, 0, 0, 1, B_PT);
        tick();
        chk("final_done_low", bus.done, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_inv_core.md
# aes_inv_core

Iterative AES-128 decryption core (FIPS-197 inverse cipher): the receive-side counterpart of the encryption core used in the lockstep encryptor wrapper. It accepts one 128-bit ciphertext block and the original 128-bit cipher key, derives the last round key on the fly, then runs the inverse rounds with an inverse key schedule. Port shape, `step_en` stall input and `state` observation output match the encryption core, so a decryptor wrapper can instantiate it in dual-core lockstep with randomized stalls.

## Interface
- No parameters (AES-128 only; Nr = 10 fixed).
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — reset, asynchronous, active-high.
- `start` input 1 — request decryption; sampled only in IDLE.
- `key` input 128 — cipher key (round key 0), sampled with `start`.
- `ciphertext` input 128 — input block, sampled with `start`.
- `step_en` input 1 — advance enable; 0 freezes all datapath/counter state while busy.
- `busy` output 1 — high from the cycle after `start` is accepted until `done`.
- `done` output 1 — one-cycle pulse; `plaintext` valid in that cycle.
- `plaintext` output 128 — result register.
- `state` output 128 — live internal state register, for lockstep compare.

## Operation
- Byte order: bit [127:120] is byte 0; columns are 32-bit words, w0 = [127:96].
- Registers: `st` (128), `rk` (128), `kreg` (captured key), step counter `cnt` (5 bits, 0–20), FSM {IDLE, KEYEXP, DEC}.
- IDLE, `start`=1: `st`<=`ciphertext`, `rk`<=`key`, `kreg`<=`key`, `cnt`<=0, -> KEYEXP. `step_en` is ignored in IDLE.
- Every step below occurs only on edges with `step_en`=1; with `step_en`=0 all registers hold.
- KEYEXP steps 1–10: `rk` <= forward expansion of `rk` with Rcon[cnt+1] (01,02,04,08,10,20,40,80,1B,36). On step 10 also `st` <= `st` ^ new `rk` (AddRoundKey with rk10); -> DEC.
- Inverse expansion from rk(i+1) = {w4..w7}: w3=w7^w6, w2=w6^w5, w1=w5^w4, w0=w4^SubWord(RotWord(w3))^Rcon[i+1].
- DEC steps 11–19 (rounds 9..1): `rk` <= inverse expansion (rk_r); `st` <= InvMixColumns(InvSubBytes(InvShiftRows(`st`)) ^ rk_r).
- DEC step 20 (final): rk0 from inverse expansion; `pt` = InvSubBytes(InvShiftRows(`st`)) ^ rk0; `st`<=`pt`, `plaintext`<=`pt`, `done`<=1, -> IDLE.
- `kreg` is optional for the datapath (rk0 from inverse expansion must equal it); implementation may drop it.
- `start` while busy: ignored; no restart, no queueing.
- `done` is the only pulse; `plaintext` holds until the next completion.
- `state` reflects `st` in all states (ciphertext after load, intermediate round values, plaintext after done).

## Timing
- Reset (async assert, released synchronously to `clk` by the system): FSM=IDLE, `busy`=0, `done`=0, `plaintext`=0, `state`=0, `cnt`=0, `rk`=0.
- Reset mid-operation aborts immediately; no `done`, outputs return to reset values.
- Latency with `step_en` held 1: `start` accepted on edge E0; `busy`=1 after E0; 20 steps on E1..E20; after E20, `done`=1 and `busy`=0 in the same cycle. A new `start` in that `done` cycle is accepted.
- Each `step_en`=0 cycle while busy adds exactly one cycle of latency; the total is 20 + (number of stall cycles).
- One S-box bank is shared between key expansion and data is not allowed: key and data paths are evaluated in the same cycle (16 inverse S-boxes for data, 4 forward S-boxes for the key).

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, `step_en`=1 -> `done` exactly 20 cycles after acceptance, `plaintext`=00112233445566778899aabbccddeeff; `state` after step 10 = ct ^ 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> `plaintext`=3243f6a8885a308d313198a2e0370734.
- Stalls: repeat C.1 with `step_en` driven by the LFSR pattern (x^16+x^14+x^13+x^11+1, seed ACE1, enable = bit0|bit1) -> same plaintext, latency = 20 + stall count, `state` frozen on every stalled cycle.
- `start` pulsed at cycles 3 and 15 of a busy run with a different key -> ignored; result still C.1 plaintext; one `done`.
- `rst` asserted asynchronously mid-DEC at step 14 -> `busy`, `done`, `plaintext`, `state` all 0 immediately; subsequent B vector decrypts correctly.
- Back-to-back: B then C.1 with the second `start` in the first `done` cycle -> two `done` pulses 21 cycles apart, correct plaintexts, `plaintext` holds B until second completion.
